wb_mem_slave: RTL and testbench
===============================

WB_MEM_SLAVE -- requirements
Module: wb_mem_slave

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024; memory size in 32-bit words, power of two, 16 to 65536.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h00000000; byte address of word 0, aligned to DEPTH_WORDS*4.
REQ-003 SHALL have parameter WAIT_STATES, default 0; extra cycles inserted before ACK_O, range 0-15.
REQ-004 SHALL have port clk, input, 1; sole clock, all state updates on rising edge.
REQ-005 SHALL have port rst, input, 1; asynchronous, active-low reset.
REQ-006 SHALL have port CYC_I, input, 1; Wishbone B4 classic cycle valid.
REQ-007 SHALL have port STB_I, input, 1; strobe.
REQ-008 SHALL have port WE_I, input, 1; 1 = write, 0 = read.
REQ-009 SHALL have port ADR_I, input, 32; byte address.
REQ-010 SHALL have port DAT_I, input, 32; write data.
REQ-011 SHALL have port SEL_I, input, 4; byte enables, bit n -> DAT_I[8n+7:8n].
REQ-012 SHALL have port DAT_O, output, 32; read data.
REQ-013 SHALL have port ACK_O, output, 1; normal termination.
REQ-014 SHALL have port ERR_O, output, 1; error termination.

Function
REQ-015 SHALL implement states IDLE, WAIT, RESP, ERROR.
REQ-016 SHALL, in IDLE with CYC_I&STB_I high at a rising edge, decode the request: misaligned (ADR_I[1:0]!=0) or out of range (ADR_I-BASE_ADDR >= DEPTH_WORDS*4) -> ERROR; otherwise WAIT if WAIT_STATES>0, else RESP.
REQ-017 SHALL latch ADR_I, WE_I, DAT_I and SEL_I at the accepting edge; later changes on these inputs do not affect the transfer.
REQ-018 SHALL load a 4-bit wait counter with WAIT_STATES-1 on entering WAIT, decrement it each cycle, and go to RESP on the edge where it equals 0.
REQ-019 SHALL assert ACK_O for exactly one cycle in RESP, registered, i.e. in cycle WAIT_STATES+1 counted from the accepting edge.
REQ-020 SHALL assert ERR_O for exactly one cycle in ERROR, never together with ACK_O; memory is left unchanged.
REQ-021 SHALL, on a read, drive the addressed word on DAT_O during the ACK_O cycle; DAT_O SHALL be 0 in every other cycle.
REQ-022 SHALL, on a write, update only the bytes with SEL_I=1, committed at the edge ending the ACK_O cycle; SEL_I=4'b0000 writes nothing but still acknowledges.
REQ-023 SHALL return from RESP and ERROR to IDLE unconditionally; if CYC_I&STB_I is still high in IDLE, that is treated as a new request (back-to-back transfers allowed, minimum 2 cycles each).
REQ-024 SHALL, if CYC_I falls while in WAIT, abort to IDLE without ACK_O/ERR_O and without a memory write.
REQ-025 SHALL, if CYC_I falls while in RESP, still complete the pending write; ACK_O is still pulsed.
REQ-026 SHALL ignore STB_I when CYC_I is low.
REQ-027 SHALL compute word index as (ADR_I-BASE_ADDR)>>2 using 32-bit unsigned subtraction; addresses below BASE_ADDR wrap to large values and are out of range.

Reset
REQ-028 SHALL, on rst low, immediately force state IDLE, ACK_O=0, ERR_O=0, DAT_O=0, wait counter 0, with no clock required.
REQ-029 SHALL discard any in-flight transfer on reset; a write not yet committed SHALL NOT reach memory.
REQ-030 SHALL NOT reset memory contents; contents after power-up are undefined.
REQ-031 SHALL ignore requests until the first rising edge after rst returns high.

Verification
REQ-032 WAIT_STATES=0: write 32'hDEADBEEF to 0x10 with SEL=4'hF, then read 0x10 -> each ACK_O exactly 1 cycle after acceptance, read DAT_O=32'hDEADBEEF.
REQ-033 SEL=4'b0101 write 32'h11223344 over 32'hDEADBEEF at 0x10 -> read returns 32'hDE22BE44.
REQ-034 WAIT_STATES=3: read 0x10 -> ACK_O in 4th cycle after acceptance; drop CYC_I in the 2nd cycle of a write -> no ACK_O, memory unchanged.
REQ-035 Reads of 0x12 (misaligned) and of DEPTH_WORDS*4 (out of range) -> ERR_O single pulse, ACK_O stays 0, DAT_O=0.
REQ-036 Assert rst low mid-WAIT during a write -> ACK_O/ERR_O/DAT_O go to 0 asynchronously, target word keeps its old value.

Source files
------------

// File: rtl/wb_mem_slave.sv
// Wishbone B4 classic single-port memory slave with configurable wait states.
// Decodes misaligned / out-of-range requests into a one-cycle error termination.
module wb_mem_slave #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        CYC_I,
  input  logic        STB_I,
  input  logic        WE_I,
  input  logic [31:0] ADR_I,
  input  logic [31:0] DAT_I,
  input  logic [3:0]  SEL_I,
  output logic [31:0] DAT_O,
  output logic        ACK_O,
  output logic        ERR_O
);

  localparam int unsigned AW      = $clog2(DEPTH_WORDS);
  localparam logic [31:0] SPAN    = 32'(DEPTH_WORDS * 4);
  localparam logic [3:0]  WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP, ERROR} state_t;

  state_t        state, next_state;
  logic [31:0]   mem [DEPTH_WORDS];
  logic [31:0]   off;
  logic          req, bad;
  logic [AW-1:0] idx_q, cur_idx;
  logic          we_q, cur_we;
  logic [31:0]   wdat_q;
  logic [3:0]    sel_q;
  logic [3:0]    cnt;

  // BASE_ADDR is word-aligned, so off[1:0] equals ADR_I[1:0].
  always_comb begin
    req        = CYC_I & STB_I;
    off        = ADR_I - BASE_ADDR;
    bad        = (off[1:0] != 2'b00) || (off >= SPAN);
    cur_idx    = (state == IDLE) ? off[AW+1:2] : idx_q;
    cur_we     = (state == IDLE) ? WE_I : we_q;
    next_state = state;
    case (state)
      IDLE: begin
        if (req) begin
          if (bad)                  next_state = ERROR;
          else if (WAIT_STATES > 0) next_state = WAIT;
          else                      next_state = RESP;
        end
      end
      WAIT: begin
        if (!CYC_I)          next_state = IDLE;
        else if (cnt == '0)  next_state = RESP;
      end
      RESP:    next_state = IDLE;
      ERROR:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= next_state;
  end

  // Outputs are registered from next_state so ACK/ERR/DAT line up with RESP/ERROR.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q  <= '0;
      we_q   <= 1'b0;
      wdat_q <= '0;
      sel_q  <= '0;
      cnt    <= '0;
      ACK_O  <= 1'b0;
      ERR_O  <= 1'b0;
      DAT_O  <= '0;
    end else begin
      if (state == IDLE && req) begin
        idx_q  <= off[AW+1:2];
        we_q   <= WE_I;
        wdat_q <= DAT_I;
        sel_q  <= SEL_I;
      end
      if (next_state == WAIT) cnt <= (state == WAIT) ? cnt - 4'd1 : WS_LOAD;
      else                    cnt <= '0;
      ACK_O <= (next_state == RESP);
      ERR_O <= (next_state == ERROR);
      DAT_O <= (next_state == RESP && !cur_we) ? mem[cur_idx] : '0;
    end
  end

  // Memory is intentionally not reset; write commits on the edge that ends ACK.
  always_ff @(posedge clk) begin
    if (state == RESP && we_q) begin
      for (int unsigned b = 0; b < 4; b++) begin
        if (sel_q[b]) mem[idx_q][8*b +: 8] <= wdat_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_mem_slave.sv
// Self-checking bench for wb_mem_slave: two instances (0 and 3 wait states)
// compared against an array-based memory model and the decode/timing rules.
module tb_wb_mem_slave;

  localparam int          DEPTH = 16;
  localparam int          NDUT  = 2;
  localparam logic [31:0] BASE1 = 32'h0000_0040;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc   [NDUT];
  logic        stb   [NDUT];
  logic        we    [NDUT];
  logic        ack   [NDUT];
  logic        err   [NDUT];
  logic [31:0] adr   [NDUT];
  logic [31:0] dat_w [NDUT];
  logic [31:0] dat_o [NDUT];
  logic [3:0]  sel   [NDUT];

  int checks   = 0;
  int failures = 0;
  logic [31:0] mdl [NDUT][DEPTH];

  always #5 clk = ~clk;

  wb_mem_slave #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(32'h0), .WAIT_STATES(0)) dut0 (
    .clk(clk), .rst(rst), .CYC_I(cyc[0]), .STB_I(stb[0]), .WE_I(we[0]), .ADR_I(adr[0]),
    .DAT_I(dat_w[0]), .SEL_I(sel[0]), .DAT_O(dat_o[0]), .ACK_O(ack[0]), .ERR_O(err[0]));

  wb_mem_slave #(.DEPTH_WORDS(DEPTH), .BASE_ADDR(BASE1), .WAIT_STATES(3)) dut1 (
    .clk(clk), .rst(rst), .CYC_I(cyc[1]), .STB_I(stb[1]), .WE_I(we[1]), .ADR_I(adr[1]),
    .DAT_I(dat_w[1]), .SEL_I(sel[1]), .DAT_O(dat_o[1]), .ACK_O(ack[1]), .ERR_O(err[1]));

  function automatic logic [31:0] base_of(input int d);
    return (d == 0) ? 32'h0 : BASE1;
  endfunction

  function automatic int ws_of(input int d);
    return (d == 0) ? 0 : 3;
  endfunction

  function automatic bit is_bad(input int d, input logic [31:0] a);
    logic [31:0] o;
    o = a - base_of(d);
    return (a[1:0] != 2'b00) || (o >= 32'(DEPTH * 4));
  endfunction

  function automatic int word_of(input int d, input logic [31:0] a);
    logic [31:0] o;
    o = a - base_of(d);
    return int'(o >> 2);
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] s);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
    return r;
  endfunction

  // Drives one classic transfer starting at a negedge; scrambles the request
  // inputs after acceptance. clean=0 if ACK&ERR overlap, DAT_O is nonzero
  // outside a read ACK, or the termination pulse lasts more than one cycle.
  task automatic bus_xfer(input int d, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] s, output int lat, output bit got_ack, output bit got_err,
                          output logic [31:0] rd, output bit clean);
    lat = 0; got_ack = 0; got_err = 0; rd = '0; clean = 1;
    cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = wr; adr[d] = a; dat_w[d] = wd; sel[d] = s;
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (n == 1) begin
        adr[d] = $urandom; dat_w[d] = $urandom; sel[d] = 4'($urandom); we[d] = ~wr;
      end
      if (ack[d] === 1'b1 && err[d] === 1'b1) clean = 0;
      if (dat_o[d] !== '0 && !(ack[d] === 1'b1 && !wr)) clean = 0;
      if (ack[d] === 1'b1 || err[d] === 1'b1) begin
        lat = n; got_ack = ack[d]; got_err = err[d]; rd = dat_o[d];
        break;
      end
    end
    cyc[d] = 1'b0; stb[d] = 1'b0;
    @(negedge clk);
    if (ack[d] !== 1'b0 || err[d] !== 1'b0 || dat_o[d] !== '0) clean = 0;
  endtask

  task automatic test_reset();
    bit seen;
    rst = 1'b1;
    for (int d = 0; d < NDUT; d++) begin
      cyc[d] = 0; stb[d] = 0; we[d] = 0; adr[d] = '0; dat_w[d] = '0; sel[d] = '0;
    end
    #1 rst = 1'b0;
    #2;
    for (int d = 0; d < NDUT; d++) begin
      checks++;
      if (ack[d] !== 1'b0 || err[d] !== 1'b0 || dat_o[d] !== '0) begin
        failures++;
        $display("FAIL reset_outputs dut%0d: ack=%b err=%b dat=%h, required 0 0 00000000", d, ack[d], err[d], dat_o[d]);
      end
    end
    seen = 0;
    cyc[0] = 1'b1; stb[0] = 1'b1; adr[0] = 32'h10;
    repeat (3) begin
      @(negedge clk);
      if (ack[0] !== 1'b0 || err[0] !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL reset_ignores_req: termination seen=%b, required 0", seen);
    end
    cyc[0] = 1'b0; stb[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_init();
    int lat; bit ga, ge, cl; logic [31:0] rd, v;
    for (int d = 0; d < NDUT; d++) begin
      for (int w = 0; w < DEPTH; w++) begin
        v = $urandom;
        bus_xfer(d, 1'b1, base_of(d) + 32'(w * 4), v, 4'hF, lat, ga, ge, rd, cl);
        checks++;
        if (!ga || ge || !cl || lat != ws_of(d) + 1) begin
          failures++;
          $display("FAIL init_write dut%0d w%0d: ack=%b err=%b clean=%b lat=%0d, required 1 0 1 lat=%0d", d, w, ga, ge, cl, lat, ws_of(d) + 1);
        end
        mdl[d][w] = v;
      end
    end
  endtask

  task automatic test_basic();
    int lat; bit ga, ge, cl; logic [31:0] rd;
    bus_xfer(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, lat, ga, ge, rd, cl);
    checks++;
    if (!ga || ge || !cl || lat != 1) begin
      failures++;
      $display("FAIL basic_write: ack=%b err=%b clean=%b lat=%0d, required 1 0 1 lat=1", ga, ge, cl, lat);
    end
    bus_xfer(0, 1'b0, 32'h10, '0, 4'hF, lat, ga, ge, rd, cl);
    checks++;
    if (!ga || ge || !cl || lat != 1 || rd !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL basic_read: ack=%b err=%b clean=%b lat=%0d dat=%h, required 1 0 1 lat=1 dat=deadbeef", ga, ge, cl, lat, rd);
    end
    bus_xfer(0, 1'b1, 32'h10, 32'h11223344, 4'b0101, lat, ga, ge, rd, cl);
    checks++;
    if (!ga || ge || !cl || lat != 1) begin
      failures++;
      $display("FAIL sel_write: ack=%b err=%b clean=%b lat=%0d, required 1 0 1 lat=1", ga, ge, cl, lat);
    end
    bus_xfer(0, 1'b0, 32'h10, '0, 4'hF, lat, ga, ge, rd, cl);
    checks++;
    if (!ga || rd !== 32'hDE22BE44) begin
      failures++;
      $display("FAIL sel_read: ack=%b dat=%h, required 1 de22be44", ga, rd);
    end
    bus_xfer(0, 1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000, lat, ga, ge, rd, cl);
    checks++;
    if (!ga || ge || !cl || lat != 1) begin
      failures++;
      $display("FAIL sel0_write_ack: ack=%b err=%b clean=%b lat=%0d, required 1 0 1 lat=1", ga, ge, cl, lat);
    end
    bus_xfer(0, 1'b0, 32'h10, '0, 4'hF, lat, ga, ge, rd, cl);
    checks++;
    if (!ga || rd !== 32'hDE22BE44) begin
      failures++;
      $display("FAIL sel0_read: ack=%b dat=%h, required 1 de22be44", ga, rd);
    end
    mdl[0][4] = 32'hDE22BE44;
  endtask

  task automatic test_errors();
    int          ed [6] = '{0, 0, 1, 1, 0, 1};
    logic [31:0] ea [6] = '{32'h12, 32'h40, 32'h3C, 32'hFFFFFFFC, 32'h12, BASE1 + 32'h40};
    bit          ew [6] = '{0, 0, 0, 0, 1, 1};
    int lat; bit ga, ge, cl; logic [31:0] rd;
    for (int i = 0; i < 6; i++) begin
      bus_xfer(ed[i], ew[i], ea[i], 32'hFFFFFFFF, 4'hF, lat, ga, ge, rd, cl);
      checks++;
      if (ga || !ge || !cl || lat != 1 || rd !== '0) begin
        failures++;
        $display("FAIL err_term dut%0d adr=%h: ack=%b err=%b clean=%b lat=%0d dat=%h, required 0 1 1 lat=1 dat=0", ed[i], ea[i], ga, ge, cl, lat, rd);
      end
    end
    for (int d = 0; d < NDUT; d++) begin
      bus_xfer(d, 1'b0, base_of(d) + 32'(d == 0 ? 32'h10 : 32'h0), '0, 4'hF, lat, ga, ge, rd, cl);
      checks++;
      if (!ga || rd !== mdl[d][d == 0 ? 4 : 0]) begin
        failures++;
        $display("FAIL err_no_write dut%0d: ack=%b dat=%h, required 1 %h", d, ga, rd, mdl[d][d == 0 ? 4 : 0]);
      end
    end
  endtask

  task automatic test_wait();
    int lat; bit ga, ge, cl; logic [31:0] rd;
    bus_xfer(1, 1'b0, BASE1 + 32'h10, '0, 4'hF, lat, ga, ge, rd, cl);
    checks++;
    if (!ga || ge || !cl || lat != 4 || rd !== mdl[1][4]) begin
      failures++;
      $display("FAIL wait_read: ack=%b err=%b clean=%b lat=%0d dat=%h, required 1 0 1 lat=4 dat=%h", ga, ge, cl, lat, rd, mdl[1][4]);
    end
  endtask

  task automatic test_abort();
    int lat; bit ga, ge, cl, seen; logic [31:0] rd;
    seen = 0;
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = BASE1 + 32'h14;
    dat_w[1] = ~mdl[1][5]; sel[1] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    if (ack[1] !== 1'b0 || err[1] !== 1'b0) seen = 1;
    @(negedge clk);
    cyc[1] = 1'b0; stb[1] = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (ack[1] !== 1'b0 || err[1] !== 1'b0) seen = 1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL abort_no_term: termination seen=%b, required 0", seen);
    end
    bus_xfer(1, 1'b0, BASE1 + 32'h14, '0, 4'hF, lat, ga, ge, rd, cl);
    checks++;
    if (!ga || lat != 4 || rd !== mdl[1][5]) begin
      failures++;
      $display("FAIL abort_mem: ack=%b lat=%0d dat=%h, required 1 lat=4 dat=%h", ga, lat, rd, mdl[1][5]);
    end
  endtask

  task automatic test_back_to_back();
    int          wd [6] = '{3, 9, 12, 3, 9, 12};
    bit          wr [6] = '{1, 1, 1, 0, 0, 0};
    logic [31:0] v;
    logic [3:0]  s;
    int gap;
    v = $urandom; s = 4'($urandom);
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = wr[0]; adr[0] = 32'(wd[0] * 4); dat_w[0] = v; sel[0] = s;
    for (int k = 0; k < 6; k++) begin
      gap = 0;
      for (int n = 1; n <= 10; n++) begin
        @(negedge clk);
        if (ack[0] === 1'b1 || err[0] === 1'b1) begin gap = n; break; end
      end
      checks++;
      if (ack[0] !== 1'b1 || gap != (k == 0 ? 1 : 2) || (!wr[k] && dat_o[0] !== mdl[0][wd[k]])) begin
        failures++;
        $display("FAIL b2b op%0d: ack=%b gap=%0d dat=%h, required 1 gap=%0d dat=%h", k, ack[0], gap, dat_o[0], k == 0 ? 1 : 2, wr[k] ? dat_o[0] : mdl[0][wd[k]]);
      end
      if (wr[k]) mdl[0][wd[k]] = merge(mdl[0][wd[k]], v, s);
      if (k < 5) begin
        v = $urandom; s = 4'($urandom);
        we[0] = wr[k+1]; adr[0] = 32'(wd[k+1] * 4); dat_w[0] = v; sel[0] = s;
      end
    end
    cyc[0] = 1'b0; stb[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    int lat, d, w; bit ga, ge, cl, wr, bad; logic [31:0] rd, a, v; logic [3:0] s;
    for (int i = 0; i < 80; i++) begin
      d  = $urandom_range(0, NDUT - 1);
      wr = 1'($urandom);
      v  = $urandom;
      s  = 4'($urandom);
      if ($urandom_range(0, 7) == 0) a = $urandom;
      else                           a = base_of(d) + 32'($urandom_range(0, DEPTH - 1)) * 4;
      bad = is_bad(d, a);
      w   = bad ? 0 : word_of(d, a);
      bus_xfer(d, wr, a, v, s, lat, ga, ge, rd, cl);
      checks++;
      if (bad) begin
        if (ga || !ge || !cl || lat != 1 || rd !== '0) begin
          failures++;
          $display("FAIL rand%0d err dut%0d adr=%h: ack=%b err=%b clean=%b lat=%0d dat=%h, required 0 1 1 lat=1 dat=0", i, d, a, ga, ge, cl, lat, rd);
        end
      end else begin
        if (!ga || ge || !cl || lat != ws_of(d) + 1 || (!wr && rd !== mdl[d][w])) begin
          failures++;
          $display("FAIL rand%0d dut%0d we=%b adr=%h: ack=%b err=%b clean=%b lat=%0d dat=%h, required 1 0 1 lat=%0d dat=%h", i, d, wr, a, ga, ge, cl, lat, rd, ws_of(d) + 1, wr ? 32'h0 : mdl[d][w]);
        end
        if (wr) mdl[d][w] = merge(mdl[d][w], v, s);
      end
    end
  endtask

  task automatic test_reset_inflight();
    int lat; bit ga, ge, cl; logic [31:0] rd;
    bus_xfer(0, 1'b1, 32'h20, 32'hA5A5_0001, 4'hF, lat, ga, ge, rd, cl);
    mdl[0][8] = 32'hA5A5_0001;
    // Reset asserted during a read ACK cycle on the zero-wait instance.
    cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h20;
    @(posedge clk);
    #1;
    checks++;
    if (ack[0] !== 1'b1 || dat_o[0] !== 32'hA5A5_0001) begin
      failures++;
      $display("FAIL pre_reset_ack: ack=%b dat=%h, required 1 a5a50001", ack[0], dat_o[0]);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (ack[0] !== 1'b0 || err[0] !== 1'b0 || dat_o[0] !== '0) begin
      failures++;
      $display("FAIL async_reset_ack: ack=%b err=%b dat=%h, required 0 0 00000000", ack[0], err[0], dat_o[0]);
    end
    cyc[0] = 1'b0; stb[0] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    // Reset asserted mid-WAIT on the three-wait instance during a write.
    cyc[1] = 1'b1; stb[1] = 1'b1; we[1] = 1'b1; adr[1] = BASE1 + 32'h1C;
    dat_w[1] = ~mdl[1][7]; sel[1] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if (ack[1] !== 1'b0 || err[1] !== 1'b0 || dat_o[1] !== '0) begin
      failures++;
      $display("FAIL async_reset_wait: ack=%b err=%b dat=%h, required 0 0 00000000", ack[1], err[1], dat_o[1]);
    end
    cyc[1] = 1'b0; stb[1] = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    bus_xfer(1, 1'b0, BASE1 + 32'h1C, '0, 4'hF, lat, ga, ge, rd, cl);
    checks++;
    if (!ga || lat != 4 || rd !== mdl[1][7]) begin
      failures++;
      $display("FAIL reset_no_write: ack=%b lat=%0d dat=%h, required 1 lat=4 dat=%h", ga, lat, rd, mdl[1][7]);
    end
    bus_xfer(0, 1'b0, 32'h20, '0, 4'hF, lat, ga, ge, rd, cl);
    checks++;
    if (!ga || lat != 1 || rd !== mdl[0][8]) begin
      failures++;
      $display("FAIL mem_survives_reset: ack=%b lat=%0d dat=%h, required 1 lat=1 dat=%h", ga, lat, rd, mdl[0][8]);
    end
  endtask

  initial begin
    test_reset();
    test_init();
    test_basic();
    test_errors();
    test_wait();
    test_abort();
    test_back_to_back();
    test_random();
    test_reset_inflight();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
